// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-cycle shifter: ALU funct codes and FSM state encoding.
package shifter_pkg;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/shift_step.sv
// One combinational shift stage; moves acc by up to 2**STEP_LOG2 bits with zero fill.
module shift_step #(
  parameter int STEP_LOG2 = 2
) (
  input  logic [31:0]        acc,
  input  logic [STEP_LOG2:0] amt,
  input  logic               dir,
  output logic [31:0]        shifted
);
  assign shifted = dir ? (acc >> amt) : (acc << amt);
endmodule

// File: rtl/shifter_sll_seq.sv
// Multi-cycle logical shifter with start/done handshake; shifts S=2**STEP_LOG2 bits per clock.
// Define SHIFTER_SRL_EN to also accept SRL (right shift, zero fill) on the same engine.
module shifter_sll_seq
  import shifter_pkg::*;
#(
  parameter int STEP_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [4:0]  dataB,
  input  logic [5:0]  Signal,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);
  localparam int S     = 1 << STEP_LOG2;
  localparam int AMT_W = STEP_LOG2 + 1;

  state_t             state, state_nx;
  logic [31:0]        acc, acc_nx, shifted, dout_nx;
  logic [4:0]         rem, rem_nx;
  logic               busy_nx, done_nx;
  logic [AMT_W-1:0]   amt;
  logic               final_step;
  logic               funct_ok;
  logic               dir;

`ifdef SHIFTER_SRL_EN
  assign funct_ok = (Signal == F_SLL) || (Signal == F_SRL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      dir <= 1'b0;
    else if (state == IDLE && start) dir <= (Signal == F_SRL);
  end
`else
  assign funct_ok = (Signal == F_SLL);
  assign dir      = 1'b0;
`endif

  // The last step covers whatever remains, which may be zero for dataB=0.
  assign final_step = (6'(rem) <= 6'(S));
  assign amt        = final_step ? AMT_W'(rem) : AMT_W'(S);

  shift_step #(.STEP_LOG2(STEP_LOG2)) u_step (
    .acc     (acc),
    .amt     (amt),
    .dir     (dir),
    .shifted (shifted)
  );

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    rem_nx   = rem;
    busy_nx  = busy;
    done_nx  = 1'b0;
    dout_nx  = dataOut;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = BUSY;
          busy_nx  = 1'b1;
          // Unsupported functs run one empty step so the result is zero.
          acc_nx   = funct_ok ? dataA : 32'd0;
          rem_nx   = funct_ok ? dataB : 5'd0;
        end
      end
      BUSY: begin
        acc_nx = shifted;
        rem_nx = rem - 5'(amt);
        if (final_step) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          dout_nx  = shifted;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= 32'd0;
      rem     <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dataOut <= 32'd0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      rem     <= rem_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      dataOut <= dout_nx;
    end
  end
endmodule
